// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM port between the CPU and the debug/loader port.
// Latches the winning request, issues one SRAM cycle, absorbs read latency and pulses ready.
`timescale 1ns/1ps
module sram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              sram_mem_ena,
  output logic              sram_wr_ena,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_ena_q, mem_ena_d;
  logic              wr_ena_q, wr_ena_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              dbg_ready_q, dbg_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_dbg;

  // On a tie the requester that did not own the previous transaction wins.
  assign gnt_dbg = dbg_req & (~cpu_req | ~last_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_ena_d   = 1'b0;
    wr_ena_d    = 1'b0;
    cpu_ready_d = 1'b0;
    dbg_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (cpu_req | dbg_req) begin
          owner_d   = gnt_dbg;
          last_d    = gnt_dbg;
          we_d      = gnt_dbg ? dbg_we    : cpu_we;
          addr_d    = gnt_dbg ? dbg_addr  : cpu_addr;
          wdata_d   = gnt_dbg ? dbg_wdata : cpu_wdata;
          mem_ena_d = 1'b1;
          wr_ena_d  = we_d;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          cpu_ready_d = ~owner_q;
          dbg_ready_d = owner_q;
          state_d     = DONE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Last wait cycle: sram_rdata is valid and captured at this edge.
        if (cnt_q == CNT_W'(1)) begin
          if (owner_q) dbg_rdata_d = sram_rdata;
          else         cpu_rdata_d = sram_rdata;
          cpu_ready_d = ~owner_q;
          dbg_ready_d = owner_q;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_ena_q   <= 1'b0;
      wr_ena_q    <= 1'b0;
      cpu_ready_q <= 1'b0;
      dbg_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_ena_q   <= mem_ena_d;
      wr_ena_q    <= wr_ena_d;
      cpu_ready_q <= cpu_ready_d;
      dbg_ready_q <= dbg_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign sram_mem_ena = mem_ena_q;
  assign sram_wr_ena  = wr_ena_q;
  assign sram_addr    = addr_q;
  assign sram_wdata   = wdata_q;
  assign cpu_ready    = cpu_ready_q;
  assign dbg_ready    = dbg_ready_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign dbg_rdata    = dbg_rdata_q;
  assign owner        = owner_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: four instances with RD_LAT 1..4, exercised one at a time
// against a queue-based reference model and a latency-accurate SRAM model.
`timescale 1ns/1ps
module tb_sram_arbiter;

  logic        clk;
  logic        rstn [4];
  logic        cpu_req [4], cpu_we [4], cpu_ready [4];
  logic [15:0] cpu_addr [4], cpu_wdata [4], cpu_rdata [4];
  logic        dbg_req [4], dbg_we [4], dbg_ready [4];
  logic [15:0] dbg_addr [4], dbg_wdata [4], dbg_rdata [4];
  logic        sram_mem_ena [4], sram_wr_ena [4], busy [4], owner [4];
  logic [15:0] sram_addr [4], sram_wdata [4], sram_rdata [4];

  int          checks, failures, cur;
  logic [15:0] ref_mem [512];
  logic [15:0] cpu_last, dbg_last;
  logic [15:0] cpu_q [$];
  logic [15:0] dbg_q [$];
  int          order_log [$];
  logic        prev_cr, prev_dr, prev_ena;
  int          w_ena, w_busy, w_cr, w_dr;
  logic        w_we;
  logic [15:0] w_addr, w_wdata;

  function automatic logic [15:0] init_word(input int a);
    if (a == 11) return 16'h1234;
    return 16'(a * 257) ^ 16'h5A3C;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    localparam int LAT = g + 1;
    logic [15:0] smem [512];
    logic [15:0] pipe [LAT];
    // SRAM model: contents reload while reset is held; read data appears LAT cycles after issue.
    always @(posedge clk) begin
      if (!rstn[g]) begin
        for (int i = 0; i < 512; i++) smem[i] <= init_word(i);
      end else if (sram_mem_ena[g] && sram_wr_ena[g]) begin
        smem[sram_addr[g][8:0]] <= sram_wdata[g];
      end
      pipe[0] <= (sram_mem_ena[g] && !sram_wr_ena[g]) ? smem[sram_addr[g][8:0]] : 16'hDEAD;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign sram_rdata[g] = pipe[LAT-1];

    sram_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT)) u_dut (
      .clk(clk), .reset(rstn[g]),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_ready(cpu_ready[g]), .cpu_rdata(cpu_rdata[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
      .dbg_wdata(dbg_wdata[g]), .dbg_ready(dbg_ready[g]), .dbg_rdata(dbg_rdata[g]),
      .sram_mem_ena(sram_mem_ena[g]), .sram_wr_ena(sram_wr_ena[g]),
      .sram_addr(sram_addr[g]), .sram_wdata(sram_wdata[g]), .sram_rdata(sram_rdata[g]),
      .busy(busy[g]), .owner(owner[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lane_rdlat=%0d actual=0x%0h required=0x%0h", nm, cur + 1, act, exp);
    end
  endtask

  // Monitor: pops the expected response whenever a ready pulse appears.
  always @(negedge clk) begin
    if (cpu_ready[cur]) begin
      if (prev_cr) chk("cpu_ready_width", 32'(prev_cr), 32'd0);
      if (cpu_q.size() == 0) chk("cpu_unexpected_ready", 32'd1, 32'd0);
      else chk("cpu_rdata", 32'(cpu_rdata[cur]), 32'(cpu_q.pop_front()));
      order_log.push_back(0);
    end
    if (dbg_ready[cur]) begin
      if (prev_dr) chk("dbg_ready_width", 32'(prev_dr), 32'd0);
      if (dbg_q.size() == 0) chk("dbg_unexpected_ready", 32'd1, 32'd0);
      else chk("dbg_rdata", 32'(dbg_rdata[cur]), 32'(dbg_q.pop_front()));
      order_log.push_back(1);
    end
    if (cpu_ready[cur] && dbg_ready[cur]) chk("both_ready", 32'd1, 32'd0);
    if (sram_mem_ena[cur] && prev_ena) chk("mem_ena_overlap", 32'd1, 32'd0);
    prev_cr  <= cpu_ready[cur];
    prev_dr  <= dbg_ready[cur];
    prev_ena <= sram_mem_ena[cur];
  end

  // Drives one transaction (called at a negedge), pushes the model's expected rdata,
  // and measures cycles until ready.
  task automatic txn(input int L, input bit who, input bit we, input logic [15:0] a,
                     input logic [15:0] wd, input int exp_lat, input bit hold);
    logic [15:0] e;
    int cnt;
    bit got;
    if (we) begin
      ref_mem[a[8:0]] = wd;
      e = who ? dbg_last : cpu_last;
    end else begin
      e = ref_mem[a[8:0]];
      if (who) dbg_last = e; else cpu_last = e;
    end
    if (who) begin
      dbg_q.push_back(e);
      dbg_we[L] = we; dbg_addr[L] = a; dbg_wdata[L] = wd; dbg_req[L] = 1'b1;
    end else begin
      cpu_q.push_back(e);
      cpu_we[L] = we; cpu_addr[L] = a; cpu_wdata[L] = wd; cpu_req[L] = 1'b1;
    end
    cnt = 0;
    got = 1'b0;
    while (cnt < 64 && !got) begin
      @(negedge clk);
      cnt++;
      got = who ? dbg_ready[L] : cpu_ready[L];
    end
    if (!got) chk(who ? "dbg_txn_timeout" : "cpu_txn_timeout", 32'd0, 32'd1);
    else if (exp_lat >= 0) chk(who ? "dbg_latency" : "cpu_latency", 32'(cnt), 32'(exp_lat));
    if (!hold) begin
      if (who) dbg_req[L] = 1'b0; else cpu_req[L] = 1'b0;
    end
  endtask

  task automatic watch(input int L, input int n);
    w_ena = 0; w_busy = 0; w_cr = 0; w_dr = 0; w_we = 1'bx; w_addr = 'x; w_wdata = 'x;
    repeat (n) begin
      @(negedge clk);
      if (sram_mem_ena[L]) begin
        w_ena++; w_we = sram_wr_ena[L]; w_addr = sram_addr[L]; w_wdata = sram_wdata[L];
      end
      if (busy[L]) w_busy++;
      if (cpu_ready[L]) w_cr++;
      if (dbg_ready[L]) w_dr++;
    end
  endtask

  task automatic chk_zero(input int L, input string tag);
    chk({tag, "_mem_ena"}, 32'(sram_mem_ena[L]), 32'd0);
    chk({tag, "_wr_ena"}, 32'(sram_wr_ena[L]), 32'd0);
    chk({tag, "_addr"}, 32'(sram_addr[L]), 32'd0);
    chk({tag, "_wdata"}, 32'(sram_wdata[L]), 32'd0);
    chk({tag, "_cpu_ready"}, 32'(cpu_ready[L]), 32'd0);
    chk({tag, "_dbg_ready"}, 32'(dbg_ready[L]), 32'd0);
    chk({tag, "_cpu_rdata"}, 32'(cpu_rdata[L]), 32'd0);
    chk({tag, "_dbg_rdata"}, 32'(dbg_rdata[L]), 32'd0);
    chk({tag, "_busy"}, 32'(busy[L]), 32'd0);
    chk({tag, "_owner"}, 32'(owner[L]), 32'd0);
  endtask

  task automatic contend(input int L, input bit who);
    for (int i = 0; i < 3; i++) begin
      txn(L, who, (i == 1), (who ? 16'h0140 : 16'h0040) + 16'(i),
          16'hA000 + 16'(i) + (who ? 16'h0010 : 16'h0000), -1, (i < 2));
    end
  endtask

  task automatic rand_drv(input int L, input bit who, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      txn(L, who, 1'($urandom_range(0, 1)), {7'd0, who, 8'($urandom)}, 16'($urandom), -1, 1'b0);
    end
  endtask

  task automatic run_lane(input int L);
    int lat;
    lat = L + 1;
    cur = L;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    cpu_last = '0; dbg_last = '0;
    cpu_q.delete(); dbg_q.delete();
    rstn[L] = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero(L, "reset_state");
    rstn[L] = 1'b1;
    repeat (2) @(negedge clk);

    fork
      txn(L, 1'b0, 1'b0, 16'h000B, 16'h0000, lat + 2, 1'b0);
      watch(L, lat + 3);
    join
    chk("rd_ena_cycles", 32'(w_ena), 32'd1);
    chk("rd_we", 32'(w_we), 32'd0);
    chk("rd_addr", 32'(w_addr), 32'h000B);
    chk("rd_busy_cycles", 32'(w_busy), 32'(lat + 2));
    chk("rd_dbg_ready", 32'(w_dr), 32'd0);
    @(negedge clk);
    fork
      txn(L, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 2, 1'b0);
      watch(L, 3);
    join
    chk("wr_ena_cycles", 32'(w_ena), 32'd1);
    chk("wr_we", 32'(w_we), 32'd1);
    chk("wr_addr", 32'(w_addr), 32'h0020);
    chk("wr_wdata", 32'(w_wdata), 32'hBEEF);
    chk("wr_busy_cycles", 32'(w_busy), 32'd2);
    chk("wr_cpu_ready", 32'(w_cr), 32'd0);
    @(negedge clk); txn(L, 1'b0, 1'b0, 16'h0020, 16'h0000, lat + 2, 1'b0);
    @(negedge clk); txn(L, 1'b0, 1'b1, 16'h0030, 16'hC0DE, 2, 1'b0);
    @(negedge clk); txn(L, 1'b1, 1'b0, 16'h0030, 16'h0000, lat + 2, 1'b0);

    // Loader owned the last transaction, so continuous contention starts with the CPU.
    @(negedge clk);
    order_log.delete();
    fork
      contend(L, 1'b0);
      contend(L, 1'b1);
    join
    @(negedge clk);
    chk("contention_grants", 32'(order_log.size()), 32'd6);
    for (int i = 0; i < order_log.size() && i < 6; i++)
      chk("grant_order", 32'(order_log[i]), 32'(i % 2));

    @(negedge clk);
    fork
      rand_drv(L, 1'b0, 16);
      rand_drv(L, 1'b1, 16);
    join
    repeat (2) @(negedge clk);

    cpu_we[L] = 1'b0; cpu_addr[L] = 16'h000B; cpu_req[L] = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", 32'(busy[L]), 32'd1);
    rstn[L] = 1'b0;
    #1;
    chk_zero(L, "async_reset");
    cpu_req[L] = 1'b0;
    cpu_last = '0; dbg_last = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    rstn[L] = 1'b1;
    @(negedge clk);
    fork
      txn(L, 1'b0, 1'b1, 16'h0050, 16'h1111, 2, 1'b0);
      txn(L, 1'b1, 1'b1, 16'h0150, 16'h2222, 5, 1'b0);
      begin
        @(negedge clk);
        chk("tie_first_owner", 32'(owner[L]), 32'd0);
        chk("tie_first_ena", 32'(sram_mem_ena[L]), 32'd1);
        repeat (2) @(negedge clk);
        chk("tie_gap_ena", 32'(sram_mem_ena[L]), 32'd0);
        @(negedge clk);
        chk("tie_second_owner", 32'(owner[L]), 32'd1);
        chk("tie_second_ena", 32'(sram_mem_ena[L]), 32'd1);
        chk("tie_second_addr", 32'(sram_addr[L]), 32'h0150);
      end
    join
    repeat (2) @(negedge clk);
    chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    chk("dbg_queue_drained", 32'(dbg_q.size()), 32'd0);
    rstn[L] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0; cur = 0;
    prev_cr = 1'b0; prev_dr = 1'b0; prev_ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rstn[i] = 1'b0;
      cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
      dbg_req[i] = 1'b0; dbg_we[i] = 1'b0; dbg_addr[i] = '0; dbg_wdata[i] = '0;
    end
    for (int L = 0; L < 4; L++) run_lane(L);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog lane_rdlat=%0d actual=timeout required=finish", cur + 1);
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
